// File: rtl/bt_redirect_ctrl_pkg.sv
// rtl/bt_redirect_ctrl_pkg.sv - shared operand-select enums, redirect FSM states and alignment helper.
// Alignment rule depends on BT_RVC_EN (compressed ISA support).
package bt_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_A_REG_A,
        OP_A_FWD,
        OP_A_CURRPC,
        OP_A_IMM
    } op_a_sel_e;

    typedef enum logic [2:0] {
        IMM_B_I,
        IMM_B_S,
        IMM_B_B,
        IMM_B_U,
        IMM_B_J,
        IMM_B_INCR_PC,
        IMM_B_INCR_ADDR
    } imm_b_sel_e;

    typedef enum logic [1:0] {
        BT_IDLE,
        BT_REDIRECT,
        BT_EXC
    } bt_ctrl_state_e;

    localparam logic [31:0] BT_INCR_RVC = 32'h2;

    // The alignment granule is the smallest legal instruction size.
`ifdef BT_RVC_EN
    localparam logic [31:0] BT_ALIGN_MASK = BT_INCR_RVC - 32'h1;
`else
    localparam logic [31:0] BT_ALIGN_MASK = (BT_INCR_RVC << 1) - 32'h1;
`endif

    function automatic logic bt_is_misaligned(input logic [31:0] target);
        return (target & BT_ALIGN_MASK) != 32'h0;
    endfunction

endpackage

// File: rtl/bt_redirect_ctrl_perf_counters.sv
// rtl/bt_redirect_ctrl_perf_counters.sv - wrapping taken / not-taken branch counters.
module bt_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_taken_i,
    input  logic             inc_not_taken_i,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] not_taken_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] not_taken_q, not_taken_d;

    always_comb begin
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (inc_taken_i) begin
            taken_d = taken_q + CNT_ONE;
        end
        if (inc_not_taken_i) begin
            not_taken_d = not_taken_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign taken_cnt_o     = taken_q;
    assign not_taken_cnt_o = not_taken_q;

endmodule

// File: rtl/bt_redirect_ctrl.sv
// rtl/bt_redirect_ctrl.sv - EX-stage branch/jump redirect controller with misaligned-target exception.
// BT_RVC_EN selects 2-byte (compressed) instead of 4-byte target alignment.
module bt_redirect_ctrl
    import bt_redirect_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_EX,
    input  logic             is_branch_EX,
    input  logic             is_jal_EX,
    input  logic             is_jalr_EX,
    input  logic             branch_taken_EX,
    input  logic             instr_is_compressed_EX,
    input  logic             flush_i,
    output op_a_sel_e        bt_a_mux_sel_o,
    output imm_b_sel_e       bt_b_mux_sel_o,
    input  logic [31:0]      bt_a_operand_i,
    input  logic [31:0]      bt_b_operand_i,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_id_o,
    output logic             stall_ex_o,
    output logic             exc_misaligned_o,
    output logic [31:0]      exc_tval_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] not_taken_cnt_o
);

    bt_ctrl_state_e state_q, state_d;
    logic [31:0]    redirect_pc_q, redirect_pc_d;
    logic [31:0]    exc_tval_q, exc_tval_d;
    logic           flush_if_id_q, flush_if_id_d;

    logic [31:0]    target;
    logic           target_misaligned;
    logic           accept;
    logic           fire;
    logic           inc_taken;
    logic           inc_not_taken;

    // The +2/+4 increment is applied inside the external operand mux.
    logic           unused_compressed;
    assign unused_compressed = instr_is_compressed_EX;

    always_comb begin
        bt_a_mux_sel_o = OP_A_CURRPC;
        bt_b_mux_sel_o = IMM_B_INCR_PC;
        if (is_jalr_EX) begin
            bt_a_mux_sel_o = OP_A_REG_A;
            bt_b_mux_sel_o = IMM_B_I;
        end else if (is_jal_EX) begin
            bt_b_mux_sel_o = IMM_B_J;
        end else if (is_branch_EX) begin
            bt_b_mux_sel_o = IMM_B_B;
        end
    end

    always_comb begin
        target = bt_a_operand_i + bt_b_operand_i;
        if (is_jalr_EX) begin
            target[0] = 1'b0;
        end
    end

    assign target_misaligned = bt_is_misaligned(target);
    // A flush kills the EX instruction outright, counters included.
    assign accept        = (state_q == BT_IDLE) && ex_valid_EX && !flush_i;
    assign fire          = accept && (is_jal_EX || is_jalr_EX || (is_branch_EX && branch_taken_EX));
    assign inc_taken     = fire && !target_misaligned;
    assign inc_not_taken = accept && !is_jal_EX && !is_jalr_EX && is_branch_EX && !branch_taken_EX;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        exc_tval_d    = exc_tval_q;
        flush_if_id_d = 1'b0;
        case (state_q)
            BT_IDLE: begin
                if (fire) begin
                    if (target_misaligned) begin
                        exc_tval_d = target;
                        state_d    = BT_EXC;
                    end else begin
                        redirect_pc_d = target;
                        flush_if_id_d = 1'b1;
                        state_d       = BT_REDIRECT;
                    end
                end
            end
            BT_REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d = BT_IDLE;
                end
            end
            BT_EXC: begin
                state_d = BT_IDLE;
            end
            default: begin
                state_d = BT_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = BT_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BT_IDLE;
            redirect_pc_q <= '0;
            exc_tval_q    <= '0;
            flush_if_id_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            exc_tval_q    <= exc_tval_d;
            flush_if_id_q <= flush_if_id_d;
        end
    end

    assign redirect_valid_o = (state_q == BT_REDIRECT);
    assign stall_ex_o       = (state_q == BT_REDIRECT);
    assign exc_misaligned_o = (state_q == BT_EXC);
    assign flush_if_id_o    = flush_if_id_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign exc_tval_o       = exc_tval_q;

    bt_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .inc_taken_i     (inc_taken),
        .inc_not_taken_i (inc_not_taken),
        .taken_cnt_o     (taken_cnt_o),
        .not_taken_cnt_o (not_taken_cnt_o)
    );

endmodule

// File: tb/tb_bt_redirect_ctrl.sv
// tb/tb_bt_redirect_ctrl.sv - self-checking bench for bt_redirect_ctrl (honours BT_RVC_EN).
module tb_bt_redirect_ctrl;
    import bt_redirect_ctrl_pkg::*;

    localparam int CNT_W = 32;
    localparam int C_NONE = 0, C_JAL = 1, C_JALR = 2, C_BR_T = 3, C_BR_NT = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             ex_valid_EX, is_branch_EX, is_jal_EX, is_jalr_EX;
    logic             branch_taken_EX, instr_is_compressed_EX, flush_i;
    op_a_sel_e        bt_a_mux_sel_o;
    imm_b_sel_e       bt_b_mux_sel_o;
    logic [31:0]      bt_a_operand_i, bt_b_operand_i;
    logic             redirect_valid_o, redirect_ready_i;
    logic [31:0]      redirect_pc_o;
    logic             flush_if_id_o, stall_ex_o, exc_misaligned_o;
    logic [31:0]      exc_tval_o;
    logic [CNT_W-1:0] taken_cnt_o, not_taken_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_taken;
    logic [CNT_W-1:0] exp_not_taken;

    bt_redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .ex_valid_EX            (ex_valid_EX),
        .is_branch_EX           (is_branch_EX),
        .is_jal_EX              (is_jal_EX),
        .is_jalr_EX             (is_jalr_EX),
        .branch_taken_EX        (branch_taken_EX),
        .instr_is_compressed_EX (instr_is_compressed_EX),
        .flush_i                (flush_i),
        .bt_a_mux_sel_o         (bt_a_mux_sel_o),
        .bt_b_mux_sel_o         (bt_b_mux_sel_o),
        .bt_a_operand_i         (bt_a_operand_i),
        .bt_b_operand_i         (bt_b_operand_i),
        .redirect_valid_o       (redirect_valid_o),
        .redirect_ready_i       (redirect_ready_i),
        .redirect_pc_o          (redirect_pc_o),
        .flush_if_id_o          (flush_if_id_o),
        .stall_ex_o             (stall_ex_o),
        .exc_misaligned_o       (exc_misaligned_o),
        .exc_tval_o             (exc_tval_o),
        .taken_cnt_o            (taken_cnt_o),
        .not_taken_cnt_o        (not_taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_ex();
        ex_valid_EX = 1'b0; is_branch_EX = 1'b0; is_jal_EX = 1'b0; is_jalr_EX = 1'b0;
        branch_taken_EX = 1'b0; instr_is_compressed_EX = 1'b0;
    endtask

    task automatic drive_ex(input int cls, input logic [31:0] a, input logic [31:0] b, input logic comp);
        ex_valid_EX = 1'b1;
        is_jal_EX = (cls == C_JAL);
        is_jalr_EX = (cls == C_JALR);
        is_branch_EX = (cls == C_BR_T) || (cls == C_BR_NT);
        branch_taken_EX = (cls == C_BR_T);
        instr_is_compressed_EX = comp;
        bt_a_operand_i = a;
        bt_b_operand_i = b;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One EX instruction from IDLE through to its return to IDLE; delay = cycles with ready low.
    task automatic run_xfer(input string name, input int cls, input logic [31:0] a, input logic [31:0] b,
                            input logic comp, input int delay);
        logic [31:0] tgt;
        logic        mis, fire;
        op_a_sel_e   ea;
        imm_b_sel_e  eb;
        drive_ex(cls, a, b, comp);
        #1;
        ea = (cls == C_JALR) ? OP_A_REG_A : OP_A_CURRPC;
        case (cls)
            C_JALR:          eb = IMM_B_I;
            C_JAL:           eb = IMM_B_J;
            C_BR_T, C_BR_NT: eb = IMM_B_B;
            default:         eb = IMM_B_INCR_PC;
        endcase
        checks++;
        if (bt_a_mux_sel_o !== ea || bt_b_mux_sel_o !== eb) begin
            errors++;
            $display("FAIL %s selects: got a=%0d b=%0d want a=%0d b=%0d", name, bt_a_mux_sel_o, bt_b_mux_sel_o, ea, eb);
        end
        tgt = a + b;
        if (cls == C_JALR) tgt = tgt & ~32'h1;
`ifdef BT_RVC_EN
        mis = tgt[0];
`else
        mis = (tgt % 4) != 0;
`endif
        fire = (cls == C_JAL) || (cls == C_JALR) || (cls == C_BR_T);
        if (fire && !mis) exp_taken = exp_taken + 1;
        if (cls == C_BR_NT) exp_not_taken = exp_not_taken + 1;
        step();
        clear_ex();
        if (fire && !mis) begin
            for (int k = 0; k <= delay; k++) begin
                redirect_ready_i = (k == delay);
                checks++;
                if (redirect_valid_o !== 1'b1 || stall_ex_o !== 1'b1 || redirect_pc_o !== tgt ||
                    flush_if_id_o !== (k == 0) || exc_misaligned_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s redirect cyc%0d: got v=%b s=%b pc=%h fl=%b exc=%b want v=1 s=1 pc=%h fl=%b exc=0",
                             name, k, redirect_valid_o, stall_ex_o, redirect_pc_o, flush_if_id_o,
                             exc_misaligned_o, tgt, (k == 0));
                end
                // EX requests while busy must be ignored.
                drive_ex(C_JAL, $urandom, $urandom, 1'b0);
                ex_valid_EX = $urandom_range(0, 1);
                step();
                clear_ex();
            end
            redirect_ready_i = 1'b0;
        end else if (fire) begin
            checks++;
            if (exc_misaligned_o !== 1'b1 || exc_tval_o !== tgt || redirect_valid_o !== 1'b0 || stall_ex_o !== 1'b0) begin
                errors++;
                $display("FAIL %s exc: got exc=%b tval=%h v=%b s=%b want exc=1 tval=%h v=0 s=0",
                         name, exc_misaligned_o, exc_tval_o, redirect_valid_o, stall_ex_o, tgt);
            end
            drive_ex(C_JAL, 32'h100, 32'h0, 1'b0);
            ex_valid_EX = $urandom_range(0, 1);
            step();
            clear_ex();
        end
        checks++;
        if (redirect_valid_o !== 1'b0 || stall_ex_o !== 1'b0 || exc_misaligned_o !== 1'b0 || flush_if_id_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got v=%b s=%b exc=%b fl=%b want all 0", name, redirect_valid_o, stall_ex_o,
                     exc_misaligned_o, flush_if_id_o);
        end
        checks++;
        if (taken_cnt_o !== exp_taken || not_taken_cnt_o !== exp_not_taken) begin
            errors++;
            $display("FAIL %s counters: got t=%0d nt=%0d want t=%0d nt=%0d", name, taken_cnt_o, not_taken_cnt_o,
                     exp_taken, exp_not_taken);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0 || flush_if_id_o !== 1'b0 || stall_ex_o !== 1'b0 ||
            exc_misaligned_o !== 1'b0 || exc_tval_o !== 32'h0 || taken_cnt_o !== '0 || not_taken_cnt_o !== '0) begin
            errors++;
            $display("FAIL %s: got v=%b pc=%h fl=%b s=%b exc=%b tval=%h t=%0d nt=%0d want all 0", name,
                     redirect_valid_o, redirect_pc_o, flush_if_id_o, stall_ex_o, exc_misaligned_o, exc_tval_o,
                     taken_cnt_o, not_taken_cnt_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_ex();
        flush_i = 1'b0;
        redirect_ready_i = 1'b0;
        bt_a_operand_i = '0;
        bt_b_operand_i = '0;
        exp_taken = '0;
        exp_not_taken = '0;
        #12;
        check_all_zero("reset");
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_xfer("jal", C_JAL, 32'h1000, 32'h20, 1'b0, 0);
        run_xfer("jalr", C_JALR, 32'h2003, 32'h0, 1'b0, 0);
        run_xfer("br_not_taken", C_BR_NT, 32'h3000, 32'h40, 1'b0, 0);
        run_xfer("stall_hold", C_BR_T, 32'h4000, 32'h80, 1'b0, 3);
        run_xfer("wrap", C_JAL, 32'hFFFF_FFF0, 32'h20, 1'b0, 0);
        run_xfer("none", C_NONE, 32'h5000, 32'h4, 1'b0, 0);
        run_xfer("jal_misaligned", C_JAL, 32'h1001, 32'h0, 1'b0, 0);
    endtask

    task automatic test_flush_redirect();
        drive_ex(C_JAL, 32'h6000, 32'h10, 1'b0);
        redirect_ready_i = 1'b0;
        exp_taken = exp_taken + 1;
        step();
        clear_ex();
        step();
        flush_i = 1'b1;
        checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h6010) begin
            errors++;
            $display("FAIL flush_second_cycle: got v=%b pc=%h want v=1 pc=6010", redirect_valid_o, redirect_pc_o);
        end
        step();
        flush_i = 1'b0;
        checks++;
        if (redirect_valid_o !== 1'b0 || stall_ex_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got v=%b s=%b want v=0 s=0", redirect_valid_o, stall_ex_o);
        end
        run_xfer("jal_after_flush", C_JAL, 32'h7000, 32'h8, 1'b0, 1);
    endtask

    task automatic test_flush_fire();
        drive_ex(C_JAL, 32'h8000, 32'h10, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        clear_ex();
        checks++;
        if (redirect_valid_o !== 1'b0 || exc_misaligned_o !== 1'b0 || taken_cnt_o !== exp_taken) begin
            errors++;
            $display("FAIL flush_with_fire: got v=%b exc=%b t=%0d want v=0 exc=0 t=%0d", redirect_valid_o,
                     exc_misaligned_o, taken_cnt_o, exp_taken);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = 2'b00;
                b[1:0] = 2'b00;
            end
            run_xfer("random", int'($urandom_range(0, 4)), a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_async_reset();
        drive_ex(C_JAL, 32'h9000, 32'h40, 1'b0);
        redirect_ready_i = 1'b0;
        step();
        clear_ex();
        checks++;
        if (redirect_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_redirect: got v=%b want 1", redirect_valid_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_taken = '0;
        exp_not_taken = '0;
        step();
        rst_ni = 1'b1;
        run_xfer("post_reset_jal", C_JAL, 32'hA000, 32'h4, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_redirect();
        test_flush_fire();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_redirect_ctrl.md
# bt_redirect_ctrl

Branch/jump redirect controller in the EX stage. Decodes the control-transfer class of the instruction in EX, steers the branch-target ALU operand mux selects, and forms the target from the selected operands. It then either raises an instruction-address-misaligned exception or issues a registered PC redirect to IF over a valid/ready handshake, stalling EX and flushing IF/ID while the redirect is outstanding. It also keeps taken/not-taken branch counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 32, width of the branch counters.

Ports (clock and reset first):
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- ex_valid_EX  in  1  valid instruction in EX.
- is_branch_EX  in  1  conditional branch.
- is_jal_EX  in  1  JAL.
- is_jalr_EX  in  1  JALR.
- branch_taken_EX  in  1  comparison result from the main ALU. Only meaningful for branches.
- instr_is_compressed_EX  in  1  EX instruction is 16-bit.
- flush_i  in  1  trap/kill from the core controller.
- bt_a_mux_sel_o  out  op_a_sel_e  operand-A select.
- bt_b_mux_sel_o  out  imm_b_sel_e  operand-B select.
- bt_a_operand_i  in  32  operand A returned from the mux.
- bt_b_operand_i  in  32  operand B returned from the mux.
- redirect_valid_o  out  1  redirect request to IF.
- redirect_ready_i  in  1  IF accepts redirect.
- redirect_pc_o  out  32  redirect target.
- flush_if_id_o  out  1  one-cycle kill of IF/ID.
- stall_ex_o  out  1  hold EX (and upstream).
- exc_misaligned_o  out  1  one-cycle misaligned-target exception.
- exc_tval_o  out  32  faulting target.
- taken_cnt_o  out  CNT_W  taken control transfers.
- not_taken_cnt_o  out  CNT_W  not-taken branches.

## Operation
Operand selects are combinational from the EX class:
- JALR: OP_A_REG_A with IMM_B_I.
- JAL: OP_A_CURRPC with IMM_B_J.
- Branch: OP_A_CURRPC with IMM_B_B.
- Otherwise: OP_A_CURRPC with IMM_B_INCR_PC.

Target computation:
- target = bt_a_operand_i + bt_b_operand_i, 32-bit modulo (wrap-around, no carry out).
- For JALR, bit 0 of the target is forced to 0.

Transfer rules:
- A transfer fires when ex_valid_EX is high in IDLE and the instruction is JAL, JALR, or a branch with branch_taken_EX high.
- A not-taken branch fires nothing and increments not_taken_cnt_o.

State machine:
- IDLE:
  - Firing with an aligned target: latch the target, increment taken_cnt_o, go to REDIRECT.
  - Firing with a misaligned target: latch the target into exc_tval_o, go to EXC.
- REDIRECT:
  - redirect_valid_o = 1 and stall_ex_o = 1.
  - flush_if_id_o pulses on the first REDIRECT cycle only.
  - Leave to IDLE on redirect_ready_i.
  - redirect_pc_o stays stable while valid is high.
- EXC:
  - exc_misaligned_o = 1 for one cycle, then return to IDLE.
  - No redirect and no taken-count increment.
- flush_i has priority in every state: next state is IDLE, and redirect_valid_o is deasserted the next cycle. This is the only case where valid drops without ready.
- When flush_i coincides with a firing instruction in IDLE, the instruction is ignored, including its counter updates.
- Counters wrap on overflow.

## Timing
- Reset values: state IDLE, redirect_valid_o 0, redirect_pc_o 0, flush_if_id_o 0, stall_ex_o 0, exc_misaligned_o 0, exc_tval_o 0, both counters 0.
- Latency: firing in cycle T produces redirect_valid_o (or exc_misaligned_o) in T+1. With ready high at T+1, the controller is back in IDLE at T+2 and can accept a new EX instruction at T+2.
- stall_ex_o is registered and asserted from T+1 through the handshake cycle.
- ex_valid_EX is ignored outside IDLE.
- Reset asserted mid-redirect returns all outputs to their reset values asynchronously.

## Configuration
- BT_RVC_EN defined (compressed ISA supported):
  - Misaligned means target[0] = 1. This cannot happen for JALR after bit 0 is cleared.
  - IMM_B_INCR_PC uses +2 for compressed instructions.
- BT_RVC_EN undefined:
  - Misaligned means target[1:0] != 0.
  - instr_is_compressed_EX is ignored and treated as 0.

## Structure
- op_a_sel_e and imm_b_sel_e come from the core's shared package.
- Add a new package enum bt_ctrl_state_e {BT_IDLE, BT_REDIRECT, BT_EXC}.
- Add a package constant BT_INCR_RVC = 32'h2.
- Sub-module bt_perf_counters holds the two CNT_W counters, with inc_taken and inc_not_taken strobes and a wrap.
- The operand mux stays external; this block only drives its selects.

## Test plan
- JAL with a = 0x1000, b = 0x0000_0020 → selects CURRPC/J. Next cycle redirect_valid_o = 1, redirect_pc_o = 0x1020, one flush_if_id_o pulse, taken_cnt_o = 1.
- JALR with a = 0x2003, b = 0 → target 0x2002.
  - With BT_RVC_EN: redirect to 0x2002.
  - Without BT_RVC_EN: exc_misaligned_o = 1, exc_tval_o = 0x2002, no redirect.
- Branch not taken → no redirect, no stall, not_taken_cnt_o increments by 1.
- Taken branch with redirect_ready_i low for 3 cycles → valid, pc and stall held stable for 4 cycles. IDLE the cycle after ready.
- flush_i in the second REDIRECT cycle → redirect_valid_o = 0 next cycle, state IDLE. A new JAL can fire after that.
- Operands 0xFFFF_FFF0 + 0x20 → redirect_pc_o = 0x0000_0010 (wrap). Also assert rst_ni mid-redirect → all outputs return to 0 immediately.
